// File: rtl/irq_pkg.sv
// Shared types and constants for the priority interrupt controller.
// Covers the controller states, the bus register offsets and the default vector base.
package irq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      SERVICE = 2'd2
   } irq_state_e;

   localparam logic [1:0] REG_MASK = 2'd0;
   localparam logic [1:0] REG_PEND = 2'd1;
   localparam logic [1:0] REG_VEC  = 2'd2;
   localparam logic [1:0] REG_EOI  = 2'd3;

   localparam logic [31:0] ISR_BASE_DEFAULT = 32'h0000_03C0;

   // Handler address for a request index: base plus one 32-bit word per line.
   function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [4:0] idx);
      return base + {25'd0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
// When no request is set, the index reads N (the spurious slot).
module irq_prio_enc #(
   parameter int N  = 8,
   parameter int IW = $clog2(N + 1)
) (
   input  logic [N-1:0]  req_i,
   output logic          valid_o,
   output logic [IW-1:0] idx_o
);

   always_comb begin
      valid_o = |req_i;
      idx_o   = IW'(N);
      // Scan downward so the last match, the lowest index, is the one kept.
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o = IW'(i);
         end
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Priority interrupt controller: captures request edges, masks and arbitrates them,
// drives the CPU intr/inta handshake and tracks a single in-service interrupt until EOI.
module irq_controller
   import irq_pkg::*;
#(
   parameter int          N_IRQ        = 8,
   parameter logic [31:0] ISR_BASE     = ISR_BASE_DEFAULT,
   parameter logic [31:0] SPURIOUS_VEC = ISR_BASE + 32'(4 * N_IRQ)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IRQ-1:0] irq_in,
   output logic             intr,
   input  logic             inta,
   input  logic             io_cs,
   input  logic             io_rd,
   input  logic             io_wr,
   input  logic [31:0]      Address,
   input  logic [31:0]      D_IN,
   output logic [31:0]      D_OUT
);

   localparam int IW = $clog2(N_IRQ + 1);

   irq_state_e       state_q, state_d;
   logic [N_IRQ-1:0] mask_q, mask_d;
   logic [N_IRQ-1:0] pend_q, pend_d;
   logic [N_IRQ-1:0] irq_prev_q;
   logic             inta_prev_q;
   logic [30:0]      vec_q, vec_d;
   logic             in_service_q, in_service_d;
   logic             intr_q, intr_d;
   logic [31:0]      dout_q, dout_d;

   logic [1:0]       reg_sel;
   logic             wr_en;
   logic             rd_en;
   logic             eoi_wr;
   logic [N_IRQ-1:0] rise;
   logic             inta_rise;
   logic [N_IRQ-1:0] act;
   logic             act_valid;
   logic [IW-1:0]    win_idx;
   logic [31:0]      win_vec;
   logic             ack;
   logic             ack_take;
   logic [N_IRQ-1:0] w1c_clr;
   logic [N_IRQ-1:0] ack_clr;
   logic [31:0]      rd_data;
   logic             unused_bits;

   assign reg_sel   = Address[3:2];
   assign wr_en     = io_cs & io_wr;
   assign rd_en     = io_cs & io_rd & ~io_wr;
   assign eoi_wr    = wr_en && (reg_sel == REG_EOI);
   assign rise      = irq_in & ~irq_prev_q;
   assign inta_rise = inta & ~inta_prev_q;
   assign act       = pend_q & ~mask_q;
   assign ack       = (state_q == ASSERT) && inta_rise;
   assign ack_take  = ack && act_valid;
   assign win_vec   = vec_addr(ISR_BASE, 5'(win_idx));
   assign w1c_clr   = (wr_en && (reg_sel == REG_PEND)) ? D_IN[N_IRQ-1:0] : '0;
   assign mask_d    = (wr_en && (reg_sel == REG_MASK)) ? D_IN[N_IRQ-1:0] : mask_q;

   assign unused_bits = ^{Address[31:4], Address[1:0], D_IN[31:N_IRQ], win_vec[31]};

   irq_prio_enc #(
      .N  (N_IRQ),
      .IW (IW)
   ) u_prio_enc (
      .req_i   (act),
      .valid_o (act_valid),
      .idx_o   (win_idx)
   );

   // A fresh edge outranks both software clear and acknowledge clear of the same bit.
   for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_pend
      assign ack_clr[gi] = ack_take && (win_idx == IW'(gi));
      assign pend_d[gi]  = rise[gi] | (pend_q[gi] & ~w1c_clr[gi] & ~ack_clr[gi]);
   end

   always_comb begin
      rd_data = '0;
      case (reg_sel)
         REG_MASK: rd_data[N_IRQ-1:0] = mask_q;
         REG_PEND: rd_data[N_IRQ-1:0] = pend_q;
         REG_VEC:  rd_data            = {in_service_q, vec_q};
         default:  rd_data            = '0;
      endcase
   end

   assign dout_d = rd_en ? rd_data : dout_q;

   always_comb begin
      state_d      = state_q;
      in_service_d = in_service_q;
      vec_d        = vec_q;
      case (state_q)
         IDLE: begin
            if (act_valid) begin
               state_d = ASSERT;
            end
         end
         ASSERT: begin
            if (inta_rise) begin
               if (act_valid) begin
                  state_d      = SERVICE;
                  in_service_d = 1'b1;
                  vec_d        = win_vec[30:0];
               end else begin
                  // Request vanished between intr and acknowledge.
                  state_d      = IDLE;
                  in_service_d = 1'b0;
                  vec_d        = SPURIOUS_VEC[30:0];
               end
            end
         end
         SERVICE: begin
            if (eoi_wr) begin
               state_d      = IDLE;
               in_service_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      intr_d = (state_d == ASSERT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         mask_q       <= '1;
         pend_q       <= '0;
         irq_prev_q   <= '0;
         inta_prev_q  <= 1'b0;
         vec_q        <= '0;
         in_service_q <= 1'b0;
         intr_q       <= 1'b0;
         dout_q       <= '0;
      end else begin
         state_q      <= state_d;
         mask_q       <= mask_d;
         pend_q       <= pend_d;
         irq_prev_q   <= irq_in;
         inta_prev_q  <= inta;
         vec_q        <= vec_d;
         in_service_q <= in_service_d;
         intr_q       <= intr_d;
         dout_q       <= dout_d;
      end
   end

   assign intr  = intr_q;
   assign D_OUT = dout_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: a cycle-by-cycle vector table for the main
// arbitration path plus hand-written sequences for masking, spurious, re-trigger, inta and reset.
module tb_irq_controller;
   import irq_pkg::*;

   localparam int N = 8;

   logic          clk;
   logic          reset;
   logic [N-1:0]  irq_in;
   logic          intr;
   logic          inta;
   logic          io_cs;
   logic          io_rd;
   logic          io_wr;
   logic [31:0]   Address;
   logic [31:0]   D_IN;
   logic [31:0]   D_OUT;

   int n_checks;
   int n_fail;

   typedef struct {
      logic         rd;
      logic         wr;
      logic [31:0]  addr;
      logic [31:0]  wdata;
      logic [N-1:0] irq;
      logic         ack;
      logic         exp_intr;
      logic         chk_dout;
      logic [31:0]  exp_dout;
   } vec_t;

   localparam int NV = 19;
   vec_t tbl [NV];

   irq_controller #(.N_IRQ(N)) dut (
      .clk     (clk),
      .reset   (reset),
      .irq_in  (irq_in),
      .intr    (intr),
      .inta    (inta),
      .io_cs   (io_cs),
      .io_rd   (io_rd),
      .io_wr   (io_wr),
      .Address (Address),
      .D_IN    (D_IN),
      .D_OUT   (D_OUT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end else begin
         $display("ok   %s: %h", name, got);
      end
   endtask

   task automatic check_intr(input string name, input logic exp);
      check32(name, {31'd0, intr}, {31'd0, exp});
   endtask

   task automatic bus_wr(input logic [1:0] r, input logic [31:0] d);
      io_cs = 1'b1; io_wr = 1'b1; Address = {28'd0, r, 2'b00}; D_IN = d;
      @(negedge clk);
      io_cs = 1'b0; io_wr = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [1:0] r, input logic [31:0] exp);
      io_cs = 1'b1; io_rd = 1'b1; Address = {28'd0, r, 2'b00};
      @(negedge clk);
      io_cs = 1'b0; io_rd = 1'b0;
      check32(name, D_OUT, exp);
   endtask

   task automatic pulse_irq(input logic [N-1:0] v);
      irq_in = v;
      @(negedge clk);
      irq_in = '0;
   endtask

   task automatic setv(input int i, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [N-1:0] irq, input logic ack,
                       input logic ei, input logic cd, input logic [31:0] ed);
      tbl[i].rd = rd; tbl[i].wr = wr; tbl[i].addr = addr; tbl[i].wdata = wd;
      tbl[i].irq = irq; tbl[i].ack = ack; tbl[i].exp_intr = ei;
      tbl[i].chk_dout = cd; tbl[i].exp_dout = ed;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset = 1'b1; irq_in = '0; inta = 1'b0;
      io_cs = 1'b0; io_rd = 1'b0; io_wr = 1'b0; Address = '0; D_IN = '0;

      //      i  rd wr addr          wdata         irq    ack ei cd exp_dout
      setv( 0, 0, 1, 32'h0000_0000, 32'h0000_00FA, 8'h00, 0, 0, 0, 32'h0);
      setv( 1, 0, 0, 32'h0000_0000, 32'h0,        8'h05, 0, 0, 0, 32'h0);
      setv( 2, 1, 0, 32'h0000_0004, 32'h0,        8'h00, 0, 1, 1, 32'h0000_0005);
      setv( 3, 0, 0, 32'h0000_0000, 32'h0,        8'h00, 0, 1, 0, 32'h0);
      setv( 4, 0, 0, 32'h0000_0000, 32'h0,        8'h00, 1, 0, 0, 32'h0);
      setv( 5, 1, 0, 32'h0000_0008, 32'h0,        8'h00, 1, 0, 1, 32'h8000_03C0);
      setv( 6, 1, 0, 32'h0000_0004, 32'h0,        8'h00, 0, 0, 1, 32'h0000_0004);
      setv( 7, 0, 1, 32'h0000_000C, 32'hDEAD_BEEF, 8'h00, 0, 0, 0, 32'h0);
      setv( 8, 0, 0, 32'h0000_0000, 32'h0,        8'h00, 0, 1, 0, 32'h0);
      setv( 9, 0, 0, 32'h0000_0000, 32'h0,        8'h00, 1, 0, 0, 32'h0);
      setv(10, 1, 0, 32'hFFFF_FFF8, 32'h0,        8'h00, 0, 0, 1, 32'h8000_03C8);
      setv(11, 1, 0, 32'h0000_0004, 32'h0,        8'h00, 0, 0, 1, 32'h0000_0000);
      setv(12, 0, 1, 32'h0000_100C, 32'h0,        8'h00, 0, 0, 0, 32'h0);
      setv(13, 0, 0, 32'h0000_0000, 32'h0,        8'h00, 0, 0, 0, 32'h0);
      setv(14, 0, 1, 32'h0000_0010, 32'hFFFF_FF3C, 8'h00, 0, 0, 0, 32'h0);
      setv(15, 1, 0, 32'h0000_0000, 32'h0,        8'h00, 0, 0, 1, 32'h0000_003C);
      setv(16, 1, 1, 32'h0000_0000, 32'h0000_00FF, 8'h00, 0, 0, 1, 32'h0000_003C);
      setv(17, 1, 0, 32'h0000_0000, 32'h0,        8'h00, 0, 0, 1, 32'h0000_00FF);
      setv(18, 1, 0, 32'h0000_000C, 32'h0,        8'h00, 0, 0, 1, 32'h0000_0000);

      // Power-on reset state.
      repeat (2) @(negedge clk);
      check_intr("reset_intr", 1'b0);
      check32("reset_dout", D_OUT, 32'h0);
      reset = 1'b0;
      rd_chk("reset_mask", REG_MASK, 32'h0000_00FF);
      rd_chk("reset_pend", REG_PEND, 32'h0);
      rd_chk("reset_vec", REG_VEC, 32'h0);

      // Priority/latency path, one table row per clock.
      for (int i = 0; i < NV; i++) begin
         io_cs = tbl[i].rd | tbl[i].wr; io_rd = tbl[i].rd; io_wr = tbl[i].wr;
         Address = tbl[i].addr; D_IN = tbl[i].wdata;
         irq_in = tbl[i].irq; inta = tbl[i].ack;
         @(negedge clk);
         check_intr($sformatf("vec%0d_intr", i), tbl[i].exp_intr);
         if (tbl[i].chk_dout) check32($sformatf("vec%0d_dout", i), D_OUT, tbl[i].exp_dout);
      end
      io_cs = 1'b0; io_rd = 1'b0; io_wr = 1'b0; irq_in = '0; inta = 1'b0;

      // Masked request stays quiet until unmasked.
      pulse_irq(8'h08);
      rd_chk("mask_pend", REG_PEND, 32'h0000_0008);
      begin
         int hits;
         hits = 0;
         repeat (20) begin
            @(negedge clk);
            if (intr !== 1'b0) hits++;
         end
         check32("mask_quiet_20", hits, 0);
      end
      bus_wr(REG_MASK, 32'h0000_00F7);
      check_intr("unmask_edge1", 1'b0);
      @(negedge clk);
      check_intr("unmask_edge2", 1'b1);
      inta = 1'b1; @(negedge clk); inta = 1'b0;
      check_intr("unmask_ack", 1'b0);
      rd_chk("unmask_vec", REG_VEC, 32'h8000_03CC);
      bus_wr(REG_EOI, 32'h0);
      bus_wr(REG_MASK, 32'h0000_00FF);

      // Spurious: request masked away between intr and inta.
      bus_wr(REG_MASK, 32'h0000_00FD);
      pulse_irq(8'h02);
      @(negedge clk);
      check_intr("spur_intr", 1'b1);
      bus_wr(REG_MASK, 32'h0000_00FF);
      check_intr("spur_hold", 1'b1);
      inta = 1'b1; @(negedge clk); inta = 1'b0;
      check_intr("spur_ack", 1'b0);
      rd_chk("spur_vec", REG_VEC, 32'h0000_03E0);
      rd_chk("spur_pend", REG_PEND, 32'h0000_0002);
      repeat (2) @(negedge clk);
      check_intr("spur_idle", 1'b0);
      bus_wr(REG_PEND, 32'h0000_0002);
      rd_chk("w1c_pend", REG_PEND, 32'h0);

      // Re-trigger during service and W1C/set collision.
      bus_wr(REG_MASK, 32'h0000_00FE);
      pulse_irq(8'h01);
      @(negedge clk);
      check_intr("retrig_intr", 1'b1);
      inta = 1'b1; @(negedge clk); inta = 1'b0;
      pulse_irq(8'h01);
      rd_chk("retrig_pend", REG_PEND, 32'h0000_0001);
      check_intr("retrig_svc_intr", 1'b0);
      bus_wr(REG_EOI, 32'h0);
      check_intr("retrig_eoi", 1'b0);
      @(negedge clk);
      check_intr("retrig_intr2", 1'b1);
      inta = 1'b1; @(negedge clk); inta = 1'b0;
      rd_chk("retrig_vec", REG_VEC, 32'h8000_03C0);
      irq_in = 8'h01;
      bus_wr(REG_PEND, 32'h0000_0001);
      irq_in = '0;
      rd_chk("collide_pend", REG_PEND, 32'h0000_0001);
      bus_wr(REG_PEND, 32'h0000_0001);
      rd_chk("collide_clr", REG_PEND, 32'h0);
      bus_wr(REG_EOI, 32'h0);

      // inta already high when ASSERT is entered is not an acknowledge.
      inta = 1'b1;
      @(negedge clk);
      pulse_irq(8'h01);
      @(negedge clk);
      check_intr("inta_held_a", 1'b1);
      repeat (3) @(negedge clk);
      check_intr("inta_held_b", 1'b1);
      rd_chk("inta_held_pend", REG_PEND, 32'h0000_0001);
      inta = 1'b0; @(negedge clk);
      check_intr("inta_low", 1'b1);
      inta = 1'b1; @(negedge clk); inta = 1'b0;
      check_intr("inta_reack", 1'b0);
      rd_chk("inta_vec", REG_VEC, 32'h8000_03C0);
      bus_wr(REG_EOI, 32'h0);

      // Asynchronous reset in the middle of service with irq 4 still pending.
      pulse_irq(8'h11);
      @(negedge clk);
      inta = 1'b1; @(negedge clk); inta = 1'b0;
      rd_chk("pre_reset_pend", REG_PEND, 32'h0000_0010);
      #2 reset = 1'b1;
      #1;
      check_intr("async_reset_intr", 1'b0);
      check32("async_reset_dout", D_OUT, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      rd_chk("post_reset_mask", REG_MASK, 32'h0000_00FF);
      rd_chk("post_reset_pend", REG_PEND, 32'h0);
      rd_chk("post_reset_vec", REG_VEC, 32'h0);
      check_intr("post_reset_intr", 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
